fp32_round_pipe: RTL and testbench

Two-stage pipelined FP32 rounding stage that consumes the unrounded-result bundle (`Structs #(.FP_FORMAT(FP32))::uround_res_t`) produced by the FP64→FP32 converter and emits the final IEEE-754 single-precision result with exception flags. It applies the selected rounding mode and resolves overflow and underflow. It also maintains a sticky accrued-flags register. Valid/ready handshakes on both sides allow it to sit between the converter and the FPU writeback buffer under backpressure.

---
 rtl/fp32_round_pipe.sv | 222 ++++++++++++++++++++++
 tb/tb_fp32_round_pipe.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_round_pipe.sv
// Two-stage FP32 rounding pipeline: S1 classifies the unrounded result and
// computes the round increment, S2 forms the final value and exception flags.
package fp32_round_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  // rs = {round, sticky}; exp_cout = {negative, overflow}
  typedef struct packed {
    fp32_t       u_result;
    logic [1:0]  rs;
    logic        round_en;
    logic        invalid;
    logic [1:0]  exp_cout;
  } uround_res_t;

  typedef enum logic [1:0] {
    CAT_PASS = 2'd0,
    CAT_UNF  = 2'd1,
    CAT_OVF  = 2'd2,
    CAT_NORM = 2'd3
  } cat_e;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

endpackage

module fp32_round_pipe
  import fp32_round_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  uround_res_t urnd_result_i,
  input  logic [2:0]  rm_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] result_o,
  output logic [4:0]  flags_o,
  input  logic        fflags_clr_i,
  output logic [4:0]  fflags_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and in_ready_o never depends on
  // in_valid_i. A stage takes new data when it is empty or its successor moves.

  logic        s1_valid_q,   s1_valid_d;
  logic        s1_sign_q,    s1_sign_d;
  logic [7:0]  s1_exp_q,     s1_exp_d;
  logic [22:0] s1_mant_q,    s1_mant_d;
  logic [2:0]  s1_rm_q,      s1_rm_d;
  logic        s1_invalid_q, s1_invalid_d;
  logic        s1_inc_q,     s1_inc_d;
  logic        s1_nx_q,      s1_nx_d;
  cat_e        s1_cat_q,     s1_cat_d;

  logic        out_valid_q,  out_valid_d;
  logic [31:0] result_q,     result_d;
  logic [4:0]  flags_q,      flags_d;
  logic [4:0]  fflags_q,     fflags_d;

  logic        s2_advance;
  logic        out_fire;
  logic [2:0]  rm_norm;
  logic        g_bit, s_bit, l_bit, in_sign;
  logic        inc_c;
  cat_e        cat_c;

  logic [30:0] sum_c;
  logic        ovf_trunc, unf_min, go_ovf;
  logic [31:0] res_c;
  logic [4:0]  flags_c;

  assign s2_advance = ~out_valid_q | out_ready_i;
  assign in_ready_o = ~s1_valid_q | s2_advance;
  assign out_fire   = out_valid_q & out_ready_i;

  // ---------------- S1: classify and compute the increment ----------------
  always_comb begin
    g_bit   = urnd_result_i.rs[1];
    s_bit   = urnd_result_i.rs[0];
    l_bit   = urnd_result_i.u_result.mant[0];
    in_sign = urnd_result_i.u_result.sign;
    rm_norm = (rm_i > RM_RMM) ? RM_RNE : rm_i;

    case (rm_norm)
      RM_RTZ:  inc_c = 1'b0;
      RM_RDN:  inc_c = in_sign & (g_bit | s_bit);
      RM_RUP:  inc_c = ~in_sign & (g_bit | s_bit);
      RM_RMM:  inc_c = g_bit;
      default: inc_c = g_bit & (s_bit | l_bit);
    endcase

    if (!urnd_result_i.round_en)
      cat_c = CAT_PASS;
    else if (urnd_result_i.exp_cout[1])
      cat_c = CAT_UNF;
    else if (urnd_result_i.exp_cout == 2'b01 || urnd_result_i.u_result.exp == 8'hFF)
      cat_c = CAT_OVF;
    else
      cat_c = CAT_NORM;
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_sign_d    = s1_sign_q;
    s1_exp_d     = s1_exp_q;
    s1_mant_d    = s1_mant_q;
    s1_rm_d      = s1_rm_q;
    s1_invalid_d = s1_invalid_q;
    s1_inc_d     = s1_inc_q;
    s1_nx_d      = s1_nx_q;
    s1_cat_d     = s1_cat_q;
    if (in_ready_o) begin
      s1_valid_d = in_valid_i;
      if (in_valid_i) begin
        s1_sign_d    = in_sign;
        s1_exp_d     = urnd_result_i.u_result.exp;
        s1_mant_d    = urnd_result_i.u_result.mant;
        s1_rm_d      = rm_norm;
        s1_invalid_d = urnd_result_i.invalid;
        s1_inc_d     = inc_c;
        s1_nx_d      = g_bit | s_bit;
        s1_cat_d     = cat_c;
      end
    end
  end

  // ---------------- S2: final value and flags ----------------
  always_comb begin
    // Mantissa carry into the exponent falls out of this single add.
    sum_c     = {s1_exp_q, s1_mant_q} + {30'd0, s1_inc_q};
    ovf_trunc = (s1_rm_q == RM_RTZ) | ((s1_rm_q == RM_RDN) & ~s1_sign_q) |
                ((s1_rm_q == RM_RUP) & s1_sign_q);
    unf_min   = ((s1_rm_q == RM_RUP) & ~s1_sign_q) | ((s1_rm_q == RM_RDN) & s1_sign_q);
    go_ovf    = (s1_cat_q == CAT_OVF) | ((s1_cat_q == CAT_NORM) & (sum_c[30:23] == 8'hFF));
    res_c     = {s1_sign_q, s1_exp_q, s1_mant_q};
    flags_c   = 5'b00000;

    if (go_ovf) begin
      res_c   = ovf_trunc ? {s1_sign_q, 8'hFE, 23'h7FFFFF} : {s1_sign_q, 8'hFF, 23'h0};
      flags_c = 5'b00101;
    end else begin
      case (s1_cat_q)
        CAT_PASS: begin
          res_c   = {s1_sign_q, s1_exp_q, s1_mant_q};
          flags_c = {s1_invalid_q, 4'b0000};
        end
        CAT_UNF: begin
          res_c   = {s1_sign_q, 30'd0, unf_min};
          flags_c = 5'b00011;
        end
        default: begin
          res_c   = {s1_sign_q, sum_c};
          flags_c = {4'b0000, s1_nx_q};
        end
      endcase
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    if (s2_advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = res_c;
        flags_d  = flags_c;
      end
    end
    // A clear coinciding with a handshake keeps only the new flags.
    fflags_d = (fflags_clr_i ? 5'b00000 : fflags_q) | (out_fire ? flags_q : 5'b00000);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_exp_q     <= 8'd0;
      s1_mant_q    <= 23'd0;
      s1_rm_q      <= RM_RNE;
      s1_invalid_q <= 1'b0;
      s1_inc_q     <= 1'b0;
      s1_nx_q      <= 1'b0;
      s1_cat_q     <= CAT_PASS;
      out_valid_q  <= 1'b0;
      result_q     <= 32'd0;
      flags_q      <= 5'd0;
      fflags_q     <= 5'd0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sign_q    <= s1_sign_d;
      s1_exp_q     <= s1_exp_d;
      s1_mant_q    <= s1_mant_d;
      s1_rm_q      <= s1_rm_d;
      s1_invalid_q <= s1_invalid_d;
      s1_inc_q     <= s1_inc_d;
      s1_nx_q      <= s1_nx_d;
      s1_cat_q     <= s1_cat_d;
      out_valid_q  <= out_valid_d;
      result_q     <= result_d;
      flags_q      <= flags_d;
      fflags_q     <= fflags_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign flags_o     = flags_q;
  assign fflags_o    = fflags_q;

endmodule

// File: tb/tb_fp32_round_pipe.sv
// Directed scoreboard bench for fp32_round_pipe: expected {result, flags}
// are queued on input handshake and popped by an output monitor.
module tb_fp32_round_pipe;
  import fp32_round_pkg::*;

  localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;

  logic        clk_i = 1'b0;
  logic        reset_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i, fflags_clr_i;
  uround_res_t urnd_result_i;
  logic [2:0]  rm_i;
  logic [31:0] result_o;
  logic [4:0]  flags_o, fflags_o;

  logic [36:0] exp_q[$];
  logic [36:0] exp_e;
  logic [31:0] held;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_accepted;
  bit          sender_done;

  fp32_round_pipe dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .urnd_result_i (urnd_result_i),
    .rm_i          (rm_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .result_o      (result_o),
    .flags_o       (flags_o),
    .fflags_clr_i  (fflags_clr_i),
    .fflags_o      (fflags_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
  endtask

  // ---------------- driver ----------------
  task automatic send(input logic [31:0] u, input logic [1:0] rs, input logic ren,
                      input logic inv, input logic [1:0] cout, input logic [2:0] rm,
                      input logic [31:0] eres, input logic [4:0] efl);
    bit acc = 1'b0;
    bit rdy;
    urnd_result_i = uround_res_t'({u, rs, ren, inv, cout});
    rm_i          = rm;
    in_valid_i    = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk_i);
      rdy = in_ready_o;
      @(posedge clk_i);
      #1;
      if (rdy) acc = 1'b1;
    end
    in_valid_i = 1'b0;
    if (acc) begin
      exp_q.push_back({eres, efl});
      n_accepted++;
    end else begin
      n_checks++;
      $display("FAIL send_timeout: got no accept expected accept for u=0x%08h", u);
    end
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_i) begin
    if (!reset_i && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got 0x%08h expected no output", result_o);
      end else begin
        exp_e = exp_q.pop_front();
        check("result", result_o, exp_e[36:5]);
        check("flags", {27'd0, flags_o}, {27'd0, exp_e[4:0]});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_i       = 1'b1;
    in_valid_i    = 1'b0;
    out_ready_i   = 1'b0;
    fflags_clr_i  = 1'b0;
    urnd_result_i = '0;
    rm_i          = 3'd0;
    n_accepted    = 0;
    sender_done   = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_flags", {27'd0, flags_o}, 32'd0);
    check("rst_fflags", {27'd0, fflags_o}, 32'd0);
    reset_i     = 1'b0;
    out_ready_i = 1'b1;

    // RNE ties, with a latency check on the first one
    send(32'h3F800000, 2'b10, 1'b1, 1'b0, 2'b00, RNE, 32'h3F800000, 5'b00001);
    check("latency_c1", {31'd0, out_valid_o}, 32'd0);
    @(posedge clk_i);
    #1;
    check("latency_c2", {31'd0, out_valid_o}, 32'd1);
    send(32'h3F800001, 2'b10, 1'b1, 1'b0, 2'b00, RNE, 32'h3F800002, 5'b00001);
    // overflow flagged by the converter
    send(32'h7F7FFFFF, 2'b11, 1'b1, 1'b0, 2'b01, RNE, 32'h7F800000, 5'b00101);
    send(32'h7F7FFFFF, 2'b11, 1'b1, 1'b0, 2'b01, RTZ, 32'h7F7FFFFF, 5'b00101);
    send(32'hFF7FFFFF, 2'b11, 1'b1, 1'b0, 2'b01, RDN, 32'hFF800000, 5'b00101);
    send(32'hFF7FFFFF, 2'b11, 1'b1, 1'b0, 2'b01, RUP, 32'hFF7FFFFF, 5'b00101);
    // overflow produced by rounding carry, and the non-carrying counterpart
    send(32'h7F7FFFFF, 2'b11, 1'b1, 1'b0, 2'b00, RNE, 32'h7F800000, 5'b00101);
    send(32'h7F7FFFFF, 2'b11, 1'b1, 1'b0, 2'b00, RTZ, 32'h7F7FFFFF, 5'b00001);
    send(32'h7F800000, 2'b00, 1'b1, 1'b0, 2'b00, RNE, 32'h7F800000, 5'b00101);
    // underflow
    send(32'h00400000, 2'b01, 1'b1, 1'b0, 2'b10, RNE, 32'h00000000, 5'b00011);
    send(32'h00400000, 2'b01, 1'b1, 1'b0, 2'b10, RUP, 32'h00000001, 5'b00011);
    send(32'h80400000, 2'b01, 1'b1, 1'b0, 2'b10, RDN, 32'h80000001, 5'b00011);
    send(32'h00400000, 2'b01, 1'b1, 1'b0, 2'b11, RNE, 32'h00000000, 5'b00011);
    // pass-through
    send(32'h7FC00000, 2'b00, 1'b0, 1'b1, 2'b00, RNE, 32'h7FC00000, 5'b10000);
    send(32'h3F800001, 2'b11, 1'b0, 1'b0, 2'b00, RUP, 32'h3F800001, 5'b00000);
    // mantissa carry, RMM, illegal rm, exact, directed rounding
    send(32'h3FFFFFFF, 2'b11, 1'b1, 1'b0, 2'b00, RNE, 32'h40000000, 5'b00001);
    send(32'h3F800000, 2'b10, 1'b1, 1'b0, 2'b00, RMM, 32'h3F800001, 5'b00001);
    send(32'h3F800001, 2'b10, 1'b1, 1'b0, 2'b00, 3'd7, 32'h3F800002, 5'b00001);
    send(32'h40490FDB, 2'b00, 1'b1, 1'b0, 2'b00, RNE, 32'h40490FDB, 5'b00000);
    send(32'hBF800000, 2'b01, 1'b1, 1'b0, 2'b00, RDN, 32'hBF800001, 5'b00001);
    send(32'h3F800000, 2'b01, 1'b1, 1'b0, 2'b00, RUP, 32'h3F800001, 5'b00001);
    wait_drain();

    // backpressure: four back-to-back inputs against a stalled consumer
    out_ready_i = 1'b0;
    n_accepted  = 0;
    sender_done = 1'b0;
    fork
      begin
        send(32'h3F800000, 2'b00, 1'b1, 1'b0, 2'b00, RNE, 32'h3F800000, 5'b00000);
        send(32'h40000001, 2'b11, 1'b1, 1'b0, 2'b00, RNE, 32'h40000002, 5'b00001);
        send(32'hC0000000, 2'b01, 1'b1, 1'b0, 2'b00, RDN, 32'hC0000001, 5'b00001);
        send(32'h41200000, 2'b10, 1'b1, 1'b0, 2'b00, RTZ, 32'h41200000, 5'b00001);
        sender_done = 1'b1;
      end
    join_none
    repeat (3) @(posedge clk_i);
    #1;
    held = result_o;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_i);
      #1;
      check("stall_stable", result_o, held);
    end
    check("bp_accepts", n_accepted, 32'd2);
    check("bp_in_ready", {31'd0, in_ready_o}, 32'd0);
    check("bp_out_valid", {31'd0, out_valid_o}, 32'd1);
    out_ready_i = 1'b1;
    for (int i = 0; i < 50 && !sender_done; i++) @(posedge clk_i);
    #1;
    check("bp_sender_done", {31'd0, sender_done}, 32'd1);
    wait_drain();

    // accrued flags
    fflags_clr_i = 1'b1;
    @(posedge clk_i);
    #1;
    fflags_clr_i = 1'b0;
    check("fflags_cleared", {27'd0, fflags_o}, 32'd0);
    send(32'h3F800001, 2'b10, 1'b1, 1'b0, 2'b00, RNE, 32'h3F800002, 5'b00001);
    send(32'h3F800000, 2'b01, 1'b1, 1'b0, 2'b00, RTZ, 32'h3F800000, 5'b00001);
    send(32'h7F7FFFFF, 2'b11, 1'b1, 1'b0, 2'b01, RNE, 32'h7F800000, 5'b00101);
    wait_drain();
    check("fflags_accum", {27'd0, fflags_o}, 32'h05);

    out_ready_i = 1'b0;
    send(32'h00400000, 2'b01, 1'b1, 1'b0, 2'b10, RNE, 32'h00000000, 5'b00011);
    for (int i = 0; i < 20 && !out_valid_o; i++) begin
      @(posedge clk_i);
      #1;
    end
    fflags_clr_i = 1'b1;
    out_ready_i  = 1'b1;
    @(posedge clk_i);
    #1;
    fflags_clr_i = 1'b0;
    check("fflags_clr_hs", {27'd0, fflags_o}, 32'h03);

    // reset with two items in flight
    out_ready_i = 1'b0;
    send(32'h3F800001, 2'b10, 1'b1, 1'b0, 2'b00, RNE, 32'h3F800002, 5'b00001);
    send(32'h3F800000, 2'b10, 1'b1, 1'b0, 2'b00, RMM, 32'h3F800001, 5'b00001);
    reset_i = 1'b1;
    exp_q.delete();
    @(posedge clk_i);
    #1;
    check("midrst_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("midrst_fflags", {27'd0, fflags_o}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready_o}, 32'd1);
    reset_i     = 1'b0;
    out_ready_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    check("midrst_no_output", {31'd0, out_valid_o}, 32'd0);

    send(32'h3F800001, 2'b10, 1'b1, 1'b0, 2'b00, RMM, 32'h3F800002, 5'b00001);
    wait_drain();
    repeat (3) @(posedge clk_i);
    #1;
    check("queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
